// File: rtl/alu_6502.sv
// alu_6502: registered 8-bit ALU for the 6502 core.
// Computes ADC/SBC/AND/ORA/EOR/shift-left/shift-right/CMP and a 6502-layout
// status byte (N V 1 B D I Z C), both captured on the rising clock edge.
// Build option: define ALU_BCD_EN to include packed-BCD correction for
// ADC/SBC; without it alu_BCD is ignored and flag bit 3 reads 0.
module alu_6502 (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] alu_ctrl,
    input  logic [7:0] alu_AI,
    input  logic [7:0] alu_BI,
    input  logic       alu_carry,
    input  logic       alu_BCD,
    output logic [7:0] alu_Y,
    output logic [7:0] alu_flags
);

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_ADC = 3'b000,
        OP_SBC = 3'b001,
        OP_AND = 3'b010,
        OP_ORA = 3'b011,
        OP_EOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_CMP = 3'b111
    } op_t;

`ifdef ALU_BCD_EN
    // Decimal add: each nibble gets +6 once it passes 9; returns {carry, Y}.
    function automatic logic [DATA_W:0] bcd_add(input logic [7:0] a,
                                                 input logic [7:0] b,
                                                 input logic       cin);
        logic [5:0] lo;
        logic [5:0] hi;
        logic       lc;
        lo = {2'b00, a[3:0]} + {2'b00, b[3:0]} + {5'b0, cin};
        if (lo > 6'd9) lo = lo + 6'd6;
        lc = (lo > 6'd15);
        hi = {2'b00, a[7:4]} + {2'b00, b[7:4]} + {5'b0, lc};
        if (hi > 6'd9) hi = hi + 6'd6;
        return {(hi > 6'd15), hi[3:0], lo[3:0]};
    endfunction

    // Decimal subtract: a nibble that borrows gets -6; returns {not-borrow, Y}.
    function automatic logic [DATA_W:0] bcd_sub(input logic [7:0] a,
                                                 input logic [7:0] b,
                                                 input logic       cin);
        logic signed [4:0] lo;
        logic signed [4:0] hi;
        logic              lb;
        logic              hb;
        lo = $signed({1'b0, a[3:0]}) - $signed({1'b0, b[3:0]}) - $signed({4'b0, ~cin});
        lb = lo[4];
        if (lb) lo = lo - 5'sd6;
        hi = $signed({1'b0, a[7:4]}) - $signed({1'b0, b[7:4]}) - $signed({4'b0, lb});
        hb = hi[4];
        if (hb) hi = hi - 5'sd6;
        return {~hb, hi[3:0], lo[3:0]};
    endfunction
`else
    logic unused_bcd;
    assign unused_bcd = alu_BCD;
`endif

    logic [DATA_W-1:0] b_op_p0;
    logic              cin_p0;
    logic [DATA_W:0]   sum_p0;
    logic              v_bin_p0;
    logic [DATA_W-1:0] y_p0;
    logic              c_p0;
    logic              v_p0;
    logic              d_p0;
    logic [DATA_W-1:0] flags_p0;

    // Shared binary adder (SBC/CMP add ~B) plus per-op result and flag select
    always_comb begin
        b_op_p0  = (op_t'(alu_ctrl) == OP_ADC) ? alu_BI : ~alu_BI;
        cin_p0   = (op_t'(alu_ctrl) == OP_CMP) ? 1'b1 : alu_carry;
        sum_p0   = {1'b0, alu_AI} + {1'b0, b_op_p0} + {{DATA_W{1'b0}}, cin_p0};
        v_bin_p0 = (alu_AI[7] == b_op_p0[7]) && (sum_p0[7] != alu_AI[7]);
        y_p0     = '0;
        c_p0     = 1'b0;
        v_p0     = 1'b0;
`ifdef ALU_BCD_EN
        d_p0     = alu_BCD;
`else
        d_p0     = 1'b0;
`endif
        case (op_t'(alu_ctrl))
            OP_ADC, OP_SBC: begin
                y_p0 = sum_p0[DATA_W-1:0];
                c_p0 = sum_p0[DATA_W];
                v_p0 = v_bin_p0;
`ifdef ALU_BCD_EN
                if (alu_BCD) begin
                    if (op_t'(alu_ctrl) == OP_ADC)
                        {c_p0, y_p0} = bcd_add(alu_AI, alu_BI, alu_carry);
                    else
                        {c_p0, y_p0} = bcd_sub(alu_AI, alu_BI, alu_carry);
                end
`endif
            end
            OP_AND: y_p0 = alu_AI & alu_BI;
            OP_ORA: y_p0 = alu_AI | alu_BI;
            OP_EOR: y_p0 = alu_AI ^ alu_BI;
            OP_SHL: begin
                y_p0 = {alu_AI[6:0], alu_carry};
                c_p0 = alu_AI[7];
            end
            OP_SHR: begin
                y_p0 = {alu_carry, alu_AI[7:1]};
                c_p0 = alu_AI[0];
            end
            OP_CMP: begin
                y_p0 = sum_p0[DATA_W-1:0];
                c_p0 = sum_p0[DATA_W];
            end
            default: y_p0 = '0;
        endcase
        flags_p0 = {y_p0[7], v_p0, 1'b1, 1'b0, d_p0, 1'b0, (y_p0 == '0), c_p0};
    end

    // ---- stage p0 -> registered outputs ----
    // Capture result and status each edge; reset forces the idle status byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_Y     <= 8'h00;
            alu_flags <= 8'h20;
        end else begin
            alu_Y     <= y_p0;
            alu_flags <= flags_p0;
        end
    end

endmodule

// File: tb/tb_alu_6502.sv
// tb_alu_6502: randomized and directed stimulus for alu_6502, checked every
// cycle against an integer-arithmetic model of the 6502 ALU rules, plus
// literal expectations for the documented corner cases.
module tb_alu_6502;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] alu_ctrl = '0;
    logic [7:0] alu_AI = '0;
    logic [7:0] alu_BI = '0;
    logic       alu_carry = 1'b0;
    logic       alu_BCD = 1'b0;
    logic [7:0] alu_Y;
    logic [7:0] alu_flags;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] exp_y;
    logic [7:0] exp_f;
    bit         lit_en = 1'b0;
    logic [7:0] lit_y = '0;
    logic [7:0] lit_f = '0;
    string      lit_name = "";
    bit         lit_chk;
    logic [7:0] lit_y_q;
    logic [7:0] lit_f_q;
    string      lit_name_q;

    alu_6502 dut (
        .clk       (clk),
        .reset     (reset),
        .alu_ctrl  (alu_ctrl),
        .alu_AI    (alu_AI),
        .alu_BI    (alu_BI),
        .alu_carry (alu_carry),
        .alu_BCD   (alu_BCD),
        .alu_Y     (alu_Y),
        .alu_flags (alu_flags)
    );

    always #5 clk = ~clk;

    // Reference: returns {flags, Y} from plain integer arithmetic
    function automatic logic [15:0] model(input int op, input int a, input int b,
                                          input int cin, input int bcd);
        int y, c, v, s, sa, sb, lo, hi, bor, d, f;
        y = 0; c = 0; v = 0; d = 0;
`ifdef ALU_BCD_EN
        d = bcd;
`else
        if (bcd > 1) d = 0;
`endif
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        case (op)
            0: begin
                s = a + b + cin;
                y = s & 255;
                c = (s > 255) ? 1 : 0;
                s = sa + sb + cin;
                v = (s > 127 || s < -128) ? 1 : 0;
                if (d != 0) begin
                    lo = (a & 15) + (b & 15) + cin;
                    if (lo > 9) lo = lo + 6;
                    hi = (a >> 4) + (b >> 4) + ((lo > 15) ? 1 : 0);
                    if (hi > 9) hi = hi + 6;
                    y = ((hi & 15) << 4) | (lo & 15);
                    c = (hi > 15) ? 1 : 0;
                end
            end
            1: begin
                s = a - b - (1 - cin);
                y = s & 255;
                c = (s >= 0) ? 1 : 0;
                s = sa - sb - (1 - cin);
                v = (s > 127 || s < -128) ? 1 : 0;
                if (d != 0) begin
                    lo = (a & 15) - (b & 15) - (1 - cin);
                    bor = (lo < 0) ? 1 : 0;
                    if (bor != 0) lo = lo - 6;
                    hi = (a >> 4) - (b >> 4) - bor;
                    c = (hi >= 0) ? 1 : 0;
                    if (hi < 0) hi = hi - 6;
                    y = ((hi & 15) << 4) | (lo & 15);
                end
            end
            2: y = a & b;
            3: y = a | b;
            4: y = a ^ b;
            5: begin y = ((a << 1) | cin) & 255; c = a >> 7; end
            6: begin y = (cin << 7) | (a >> 1); c = a & 1; end
            default: begin
                y = (a - b) & 255;
                c = (a >= b) ? 1 : 0;
            end
        endcase
        f = ((y >> 7) << 7) | (v << 6) | 32 | (d << 3) | ((y == 0 ? 1 : 0) << 1) | c;
        return {8'(f), 8'(y)};
    endfunction

    // Expected outputs advance on the same edge and reset as the DUT
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_y   <= 8'h00;
            exp_f   <= 8'h20;
            lit_chk <= 1'b0;
        end else begin
            {exp_f, exp_y} <= model(int'(alu_ctrl), int'(alu_AI), int'(alu_BI),
                                    int'(alu_carry), int'(alu_BCD));
            lit_chk    <= lit_en;
            lit_y_q    <= lit_y;
            lit_f_q    <= lit_f;
            lit_name_q <= lit_name;
        end
    end

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %02h, expected %02h (t=%0t)", nm, got, want, $time);
    endtask

    // Compare process: outputs are settled mid-cycle
    always @(negedge clk) begin
        check("model_Y", alu_Y, exp_y);
        check("model_flags", alu_flags, exp_f);
        if (lit_chk) begin
            check({lit_name_q, "_Y"}, alu_Y, lit_y_q);
            check({lit_name_q, "_flags"}, alu_flags, lit_f_q);
        end
    end

    // Present one op for the next edge; called at posedge+2
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic bd, input bit lit,
                         input logic [7:0] ly, input logic [7:0] lf, input string nm);
        alu_ctrl  = op;
        alu_AI    = a;
        alu_BI    = b;
        alu_carry = ci;
        alu_BCD   = bd;
        lit_en    = lit;
        lit_y     = ly;
        lit_f     = lf;
        lit_name  = nm;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        issue(3'b000, 8'h50, 8'h50, 1'b0, 1'b0, 1, 8'hA0, 8'hE0, "adc_ovf");
        issue(3'b001, 8'h50, 8'hB0, 1'b1, 1'b0, 1, 8'hA0, 8'hE0, "sbc_ovf");
        issue(3'b110, 8'h81, 8'h00, 1'b1, 1'b0, 1, 8'hC0, 8'hA1, "shr_fill");
        issue(3'b101, 8'h80, 8'h00, 1'b0, 1'b0, 1, 8'h00, 8'h23, "shl_zero");
        issue(3'b111, 8'h40, 8'h40, 1'b0, 1'b0, 1, 8'h00, 8'h23, "cmp_eq");
        issue(3'b111, 8'h10, 8'h20, 1'b1, 1'b0, 1, 8'hF0, 8'hA0, "cmp_lt");
        issue(3'b010, 8'hF0, 8'h0F, 1'b1, 1'b0, 1, 8'h00, 8'h22, "and_zero");
        issue(3'b100, 8'hFF, 8'h7F, 1'b1, 1'b1, 1, 8'h80,
`ifdef ALU_BCD_EN
              8'hA8,
`else
              8'hA0,
`endif
              "eor_dbit");
`ifdef ALU_BCD_EN
        issue(3'b000, 8'h99, 8'h01, 1'b0, 1'b1, 1, 8'h00, 8'h2B, "bcd_adc_wrap");
        issue(3'b000, 8'h19, 8'h28, 1'b0, 1'b1, 1, 8'h47, 8'h28, "bcd_adc_mid");
        issue(3'b001, 8'h00, 8'h01, 1'b1, 1'b1, 1, 8'h99, 8'hA8, "bcd_sbc_wrap");
`else
        issue(3'b000, 8'h99, 8'h01, 1'b0, 1'b1, 1, 8'h9A, 8'hA0, "nobcd_adc");
        issue(3'b001, 8'h00, 8'h01, 1'b1, 1'b1, 1, 8'hFF, 8'hA0, "nobcd_sbc");
`endif
        // Reset in the middle of a stream of ADCs
        for (int i = 0; i < 4; i++)
            issue(3'b000, 8'(8'h11 * (i + 1)), 8'h22, 1'b1, 1'b0, 0, 8'h00, 8'h00, "");
        reset = 1'b1;
        for (int i = 0; i < 3; i++)
            issue(3'b000, 8'h7F, 8'h01, 1'b0, 1'b0, 0, 8'h00, 8'h00, "");
        reset = 1'b0;
        issue(3'b000, 8'h7F, 8'h01, 1'b0, 1'b0, 1, 8'h80, 8'hE0, "post_reset_adc");
        // Random traffic
        for (int i = 0; i < 1500; i++)
            issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  0, 8'h00, 8'h00, "");
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
